// File: rtl/i2c_monitor_pkg.sv
// Shared types and word layout for the I2C bus monitor.
package i2c_monitor_pkg;

    // Capture FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StData = 2'd1,
        StAck  = 2'd2
    } mon_state_e;

    // CPU-visible word layout; [7:0] holds the captured byte
    localparam int unsigned WAck   = 8;
    localparam int unsigned WFirst = 9;
    localparam int unsigned WOvf   = 10;
    localparam int unsigned WValid = 11;
    localparam int unsigned WordW  = 12;

    // FIFO entries hold byte, ack and first; valid/overflow are added on read
    localparam int unsigned EntryW = 10;

    function automatic logic [WordW-1:0] make_word(input logic valid,
                                                   input logic ovf,
                                                   input logic [EntryW-1:0] entry);
        logic [WordW-1:0] w;
        w              = '0;
        w[EntryW-1:0]  = entry;
        w[WOvf]        = ovf;
        w[WValid]      = valid;
        return w;
    endfunction

endpackage

// File: rtl/i2c_monitor_glitch_filter.sv
// Two-flop synchroniser followed by a level filter: the output follows the
// synchronised input only after FILTER_LEN consecutive samples at the new level.
module i2c_monitor_glitch_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic line_o
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic            sync1_q, sync2_q;
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Synchroniser; idle bus level is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples differing from the accepted level
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Filter state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/i2c_monitor.sv
// Passive I2C bus monitor: filters SCL/SDA, tracks START/STOP framing, captures
// bytes with their ACK bit into a FIFO read by the CPU over a shared data bus.
// Optional feature: define I2C_MON_ADDR_MATCH_EN to keep only transactions whose
// address byte matches MATCH_ADDR.
module i2c_monitor
    import i2c_monitor_pkg::*;
#(
    parameter int unsigned DBUS_W     = 12,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FILTER_LEN = 3,
    parameter logic [6:0]  MATCH_ADDR = 7'h50
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              scl_in,
    input  logic              sda_in,
    input  logic              rd,
    inout  logic [DBUS_W-1:0] dbus,
    output logic              irq
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic scl_f, sda_f;
    logic scl_prev_q, sda_prev_q;
    logic ev_start, ev_stop, ev_rise;
    logic addr_ok;

    mon_state_e        state_q;
    logic [2:0]        bit_q;
    logic [7:0]        byte_q;
    logic              first_q;
    logic              drop_q;
    logic              push_q;
    logic [EntryW-1:0] push_entry_q;

    logic [EntryW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              irq_q;
    logic              rd_q;
    logic              pop, full, wr_en;
    logic [WordW-1:0]  head_word;

    i2c_monitor_glitch_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_scl_filter (
        .clk_i  (clk),
        .rst_ni (nrst),
        .line_i (scl_in),
        .line_o (scl_f)
    );

    i2c_monitor_glitch_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sda_filter (
        .clk_i  (clk),
        .rst_ni (nrst),
        .line_i (sda_in),
        .line_o (sda_f)
    );

    // Previous filtered levels; reset high so releasing reset on an idle bus is silent
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    // Bus event decode; SDA transitions count only while SCL stays high
    always_comb begin
        ev_start = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
        ev_stop  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
        ev_rise  = scl_f & ~scl_prev_q;
    end

`ifdef I2C_MON_ADDR_MATCH_EN
    // Address byte decides whether this transaction is captured
    always_comb begin
        addr_ok = ~first_q | (byte_q[7:1] == MATCH_ADDR);
    end
`else
    logic unused_match_addr;
    assign unused_match_addr = ^MATCH_ADDR;

    // Every byte is captured
    always_comb begin
        addr_ok = 1'b1;
    end
`endif

    // Capture FSM: shifts data bits, samples ACK and issues a one-cycle push
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StIdle;
            bit_q        <= '0;
            byte_q       <= '0;
            first_q      <= 1'b0;
            drop_q       <= 1'b0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (ev_stop) begin
                state_q <= StIdle;
            end else if (ev_start) begin
                state_q <= StData;
                bit_q   <= '0;
                first_q <= 1'b1;
                drop_q  <= 1'b0;
            end else if (ev_rise) begin
                case (state_q)
                    StData: begin
                        byte_q <= {byte_q[6:0], sda_f};
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= StAck;
                        end
                    end
                    StAck: begin
                        if (addr_ok && !drop_q) begin
                            push_q       <= 1'b1;
                            push_entry_q <= {first_q, sda_f, byte_q};
                        end else begin
                            drop_q <= 1'b1;
                        end
                        first_q <= 1'b0;
                        bit_q   <= '0;
                        state_q <= StData;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // FIFO control: pop on rd falling edge, push from FSM, overflow when full without pop
    always_comb begin
        pop      = rd_q & ~rd & (count_q != '0);
        full     = (count_q == CntW'(FIFO_DEPTH));
        wr_en    = push_q & (~full | pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            ovf_d    = 1'b0;
        end
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end
        if (push_q && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // FIFO bookkeeping and registered irq
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_q    <= (count_d != '0);
            rd_q     <= rd;
        end
    end

    // FIFO storage; contents are qualified by count so need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_entry_q;
        end
    end

    // Head word presented on the bus; all-zero when empty
    always_comb begin
        head_word = '0;
        if (count_q != '0) begin
            head_word = make_word(1'b1, ovf_q, mem_q[rd_ptr_q]);
        end
    end

    assign dbus = rd ? DBUS_W'(head_word) : {DBUS_W{1'bz}};
    assign irq  = irq_q;

endmodule

// File: tb/tb_i2c_monitor.sv
// Self-checking bench for i2c_monitor: bit-banged I2C traffic, a reference
// queue of expected FIFO words, and CPU reads compared against it.
module tb_i2c_monitor;

    localparam int unsigned Depth = 8;
    localparam int          Ph    = 8;

    logic        clk  = 1'b0;
    logic        nrst = 1'b0;
    logic        scl  = 1'b1;
    logic        sda  = 1'b1;
    logic        rd   = 1'b0;
    wire  [11:0] dbus;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of queued entries {first, ack, byte}
    logic [9:0] mq[$];
    logic       movf  = 1'b0;
    logic       mdrop = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic        nack;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[6];

    i2c_monitor #(
        .DBUS_W     (12),
        .FIFO_DEPTH (Depth),
        .FILTER_LEN (3),
        .MATCH_ADDR (7'h50)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .scl_in (scl),
        .sda_in (sda),
        .rd     (rd),
        .dbus   (dbus),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%03h, expected 0x%03h", name, got, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] data, input logic nack, input logic first);
`ifdef I2C_MON_ADDR_MATCH_EN
        if (first) mdrop = (data[7:1] != 7'h50);
        if (mdrop) return;
`endif
        if (mq.size() < Depth) mq.push_back({first, nack, data});
        else movf = 1'b1;
    endtask

    task automatic bus_start();
        sda = 1'b1; tick(Ph);
        scl = 1'b1; tick(Ph);
        sda = 1'b0; tick(Ph);
        scl = 1'b0; tick(Ph);
    endtask

    task automatic bus_stop();
        sda = 1'b0; tick(Ph);
        scl = 1'b1; tick(Ph);
        sda = 1'b1; tick(Ph);
    endtask

    // Optional 2-clk inverted SDA glitch while SCL is high
    task automatic send_bit(input logic b, input logic glitch);
        sda = b; tick(Ph);
        scl = 1'b1;
        if (glitch) begin
            tick(3);
            sda = ~b; tick(2);
            sda = b;  tick(Ph);
        end else begin
            tick(Ph);
        end
        scl = 1'b0; tick(Ph);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic nack, input logic first,
                             input logic glitch);
        for (int i = 7; i >= 0; i--) send_bit(data[i], glitch);
        send_bit(nack, glitch);
        model_push(data, nack, first);
    endtask

    // CPU read: sample head word while rd high, pop on release, then check irq
    task automatic do_read(input string name, output logic [11:0] got);
        logic [11:0] exp;
        tick(1);
        rd = 1'b1;
        @(negedge clk);
        got = dbus;
        exp = '0;
        if (mq.size() != 0) begin
            exp  = {1'b1, movf, mq.pop_front()};
            movf = 1'b0;
        end
        check(name, got, exp);
        @(posedge clk); #1;
        rd = 1'b0;
        tick(2);
        check({name, "_irq"}, {11'd0, irq}, {11'd0, mq.size() != 0});
    endtask

    initial begin
        logic [11:0] got;

        tbl[0] = '{8'hA0, 1'b0, 12'hAA0};
        tbl[1] = '{8'h3C, 1'b1, 12'h93C};
        tbl[2] = '{8'hFF, 1'b0, 12'h8FF};
        tbl[3] = '{8'h00, 1'b1, 12'h900};
        tbl[4] = '{8'h5A, 1'b0, 12'h85A};
        tbl[5] = '{8'h81, 1'b1, 12'h981};

        // Reset state
        tick(3);
        check("reset_irq", {11'd0, irq}, 12'd0);
        nrst = 1'b1;
        tick(10);
        check("post_reset_irq", {11'd0, irq}, 12'd0);
        do_read("reset_read", got);

        // Table-driven transaction: one START, several bytes, STOP
        bus_start();
        for (int i = 0; i < 6; i++) send_byte(tbl[i].data, tbl[i].nack, i == 0, 1'b0);
        bus_stop();
        tick(5);
        check("tbl_irq_set", {11'd0, irq}, 12'd1);
        for (int i = 0; i < 6; i++) begin
            do_read($sformatf("tbl_rd%0d", i), got);
`ifndef I2C_MON_ADDR_MATCH_EN
            check($sformatf("tbl_const%0d", i), got, tbl[i].exp);
`endif
        end
        do_read("tbl_empty", got);
        check("tbl_empty_const", got, 12'h000);

        // Repeated START after a partial byte discards it
        bus_start();
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
        bus_start();
        send_byte(8'h51, 1'b0, 1'b1, 1'b0);
        bus_stop();
        do_read("rstart_rd", got);
        do_read("rstart_empty", got);

        // Overflow: one more byte than the FIFO holds
        bus_start();
        for (int i = 0; i <= Depth; i++) begin
            send_byte((i == 0) ? 8'hA0 : 8'(i * 17), i[0], i == 0, 1'b0);
        end
        bus_stop();
        for (int i = 0; i <= Depth; i++) do_read($sformatf("ovf_rd%0d", i), got);

        // Short SDA pulses on an idle bus, then glitches inside a byte
        for (int w = 1; w <= 2; w++) begin
            sda = 1'b0; tick(w);
            sda = 1'b1; tick(Ph);
        end
        check("glitch_idle_irq", {11'd0, irq}, 12'd0);
        bus_start();
        send_byte(8'hA6, 1'b0, 1'b1, 1'b1);
        send_byte(8'h12, 1'b0, 1'b0, 1'b1);
        bus_stop();
        do_read("glitch_rd0", got);
        do_read("glitch_rd1", got);
        do_read("glitch_empty", got);

        // Asynchronous reset mid-byte with words queued
        bus_start();
        for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 1'b0, i == 0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        check("pre_rst_irq", {11'd0, irq}, 12'd1);
        nrst = 1'b0;
        #1;
        check("mid_rst_irq", {11'd0, irq}, 12'd0);
        mq.delete();
        movf  = 1'b0;
        mdrop = 1'b0;
        scl = 1'b1;
        sda = 1'b1;
        tick(3);
        nrst = 1'b1;
        tick(20);
        check("rel_rst_irq", {11'd0, irq}, 12'd0);
        do_read("rel_rst_empty", got);
        bus_start();
        send_byte(8'h77, 1'b1, 1'b1, 1'b0);
        bus_stop();
        do_read("after_rst_rd", got);
        do_read("after_rst_empty", got);

        // Address match: 0xA0 transaction, then 0xA2 transaction
        bus_start();
        send_byte(8'hA0, 1'b0, 1'b1, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0, 1'b0);
        bus_stop();
        bus_start();
        send_byte(8'hA2, 1'b0, 1'b1, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0);
        bus_stop();
        for (int i = 0; i < 5; i++) do_read($sformatf("addr_rd%0d", i), got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
